// File: rtl/pid_pkg.sv
// Shared definitions for the pipelined PID controller.
//   pid_state_e : controller sequencing states (IDLE, MUL, SUM, OUT)
//   ew_w/pw_w/sw_w : widths of error, product and internal-sum datapaths
//   sat_hi_lim/sat_lo_lim : clamp limits for an unsigned or symmetric signed output
package pid_pkg;

    typedef enum logic [1:0] {IDLE, MUL, SUM, OUT} pid_state_e;

    localparam int PID_DW   = 8;
    localparam int PID_GW   = 8;
    localparam int PID_FRAC = 4;
    localparam int PID_IW   = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Error is the signed difference of two unsigned samples: one extra bit.
    function automatic int ew_w(input int dw);
        return dw + 1;
    endfunction

    // Signed error times zero-extended unsigned gain.
    function automatic int pw_w(input int dw, input int gw);
        return ew_w(dw) + gw + 1;
    endfunction

    // Room for p + integ + d (d carries a one-bit-wider error difference).
    function automatic int sw_w(input int dw, input int gw, input int iw);
        return max_int(pw_w(dw, gw), iw) + 2;
    endfunction

    // Clamp limits: sym=0 -> [0, 2^ow-1], sym=1 -> +/-(2^(ow-1)-1).
    function automatic longint sat_hi_lim(input int ow, input bit sym);
        return sym ? ((64'sd1 <<< (ow - 1)) - 64'sd1) : ((64'sd1 <<< ow) - 64'sd1);
    endfunction

    function automatic longint sat_lo_lim(input int ow, input bit sym);
        return sym ? (64'sd1 - (64'sd1 <<< (ow - 1))) : 64'sd0;
    endfunction

endpackage

// File: rtl/pid_sat.sv
// Saturating narrower for a signed internal value (SW <= 64 bits).
//   din    in  SW  signed value to clamp
//   dout   out OW  clamped value (unsigned when SYM=0, two's complement when SYM=1)
//   sat_hi out 1   din was above the upper limit
//   sat_lo out 1   din was below the lower limit
module pid_sat
    import pid_pkg::*;
#(
    parameter int SW  = 20,
    parameter int OW  = 8,
    parameter bit SYM = 1'b0
) (
    input  logic signed [SW-1:0] din,
    output logic        [OW-1:0] dout,
    output logic                 sat_hi,
    output logic                 sat_lo
);

    localparam longint HI = sat_hi_lim(OW, SYM);
    localparam longint LO = sat_lo_lim(OW, SYM);

    longint din_ext;

    assign din_ext = longint'(din);
    assign sat_hi  = (din_ext > HI);
    assign sat_lo  = (din_ext < LO);
    assign dout    = sat_hi ? HI[OW-1:0] : (sat_lo ? LO[OW-1:0] : din[OW-1:0]);

endmodule

// File: rtl/pid_ctrl_pipe.sv
// Multi-cycle PID controller, one sample in flight.
//   clk, rst_n           clock, asynchronous active-low reset
//   clear                sync: zero integrator/history, abort in-flight sample
//   in_valid/in_ready    sample handshake (setpoint, feedback, kp, ki, kd)
//   out_valid/out_ready  result handshake (control, sat_hi, sat_lo)
// Flow: IDLE (latch error, gains) -> MUL (products) -> SUM (integrate, clamp) -> OUT.
module pid_ctrl_pipe
    import pid_pkg::*;
#(
    parameter int DW   = PID_DW,
    parameter int GW   = PID_GW,
    parameter int FRAC = PID_FRAC,
    parameter int IW   = PID_IW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] setpoint,
    input  logic [DW-1:0] feedback,
    input  logic [GW-1:0] kp,
    input  logic [GW-1:0] ki,
    input  logic [GW-1:0] kd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] control,
    output logic          sat_hi,
    output logic          sat_lo
);

    localparam int EW = ew_w(DW);
    localparam int SW = sw_w(DW, GW, IW);

    pid_state_e state_q, state_d;

    logic signed [EW-1:0] e_q, prev_q;
    logic        [GW-1:0] kp_q, ki_q, kd_q;
    logic signed [SW-1:0] p_q, i_q, d_q;
    logic signed [IW-1:0] integ_q;
    logic                 first_q;

    // ---------------- sequencing ----------------
    // NOTE: state and datapath registers use non-blocking assignments with the
    // asynchronous reset in the sensitivity list; combinational blocks use blocking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every output of this block is assigned a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (in_valid) state_d = MUL;
                MUL:     state_d = SUM;
                SUM:     state_d = OUT;
                OUT:     if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign in_ready = (state_q == IDLE) && !clear;

    // ---------------- arithmetic ----------------
    logic signed [SW-1:0] e_x, diff_x, kp_x, ki_x, kd_x;

    assign e_x    = SW'(e_q);
    assign diff_x = SW'(e_q) - SW'(prev_q);
    assign kp_x   = $signed(SW'(kp_q));
    assign ki_x   = $signed(SW'(ki_q));
    assign kd_x   = $signed(SW'(kd_q));

    // Anti-windup: freeze the integrator while pushing further into the last saturation.
    logic e_pos, e_neg, hold;
    assign e_neg = e_q[EW-1];
    assign e_pos = !e_q[EW-1] && (e_q != '0);
    assign hold  = (sat_hi && e_pos) || (sat_lo && e_neg);

    logic signed [SW-1:0] integ_sum, sum, u;
    logic        [IW-1:0] integ_clamped;
    logic signed [IW-1:0] integ_next;
    logic                 unused_isat_hi, unused_isat_lo;

    assign integ_sum = SW'(integ_q) + i_q;

    pid_sat #(.SW(SW), .OW(IW), .SYM(1'b1)) u_integ_sat (
        .din    (integ_sum),
        .dout   (integ_clamped),
        .sat_hi (unused_isat_hi),
        .sat_lo (unused_isat_lo)
    );

    assign integ_next = hold ? integ_q : $signed(integ_clamped);
    assign sum        = p_q + SW'(integ_next) + d_q;
    assign u          = sum >>> FRAC;

    logic [DW-1:0] control_n;
    logic          sat_hi_n, sat_lo_n;

    pid_sat #(.SW(SW), .OW(DW), .SYM(1'b0)) u_out_sat (
        .din    (u),
        .dout   (control_n),
        .sat_hi (sat_hi_n),
        .sat_lo (sat_lo_n)
    );

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q       <= '0;
            prev_q    <= '0;
            kp_q      <= '0;
            ki_q      <= '0;
            kd_q      <= '0;
            p_q       <= '0;
            i_q       <= '0;
            d_q       <= '0;
            integ_q   <= '0;
            first_q   <= 1'b1;
            control   <= '0;
            sat_hi    <= 1'b0;
            sat_lo    <= 1'b0;
            out_valid <= 1'b0;
        end else if (clear) begin
            integ_q   <= '0;
            prev_q    <= '0;
            first_q   <= 1'b1;
            sat_hi    <= 1'b0;
            sat_lo    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    e_q  <= $signed({1'b0, setpoint}) - $signed({1'b0, feedback});
                    kp_q <= kp;
                    ki_q <= ki;
                    kd_q <= kd;
                end
                MUL: begin
                    p_q <= kp_x * e_x;
                    i_q <= ki_x * e_x;
                    d_q <= first_q ? '0 : kd_x * diff_x;
                end
                SUM: begin
                    integ_q   <= integ_next;
                    control   <= control_n;
                    sat_hi    <= sat_hi_n;
                    sat_lo    <= sat_lo_n;
                    prev_q    <= e_q;
                    first_q   <= 1'b0;
                    out_valid <= 1'b1;
                end
                OUT: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pid_ctrl_pipe.sv
// Directed bench for pid_ctrl_pipe at default parameters; expected values hand-computed.
module tb_pid_ctrl_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] setpoint = '0, feedback = '0;
    logic [7:0] kp = '0, ki = '0, kd = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] control;
    logic       sat_hi, sat_lo;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pid_ctrl_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .setpoint  (setpoint),
        .feedback  (feedback),
        .kp        (kp),
        .ki        (ki),
        .kd        (kd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .control   (control),
        .sat_hi    (sat_hi),
        .sat_lo    (sat_lo)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pulse_clear(input string tag);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        check({tag, ".clr_ov"}, out_valid, 0);
    endtask

    // Send one sample, expect the result 3 edges after (counting the accept edge),
    // optionally stall the output for `hold` cycles, then complete the transfer.
    task automatic run_sample(input string tag,
                              input logic [7:0] sp, input logic [7:0] fb,
                              input logic [7:0] gp, input logic [7:0] gi, input logic [7:0] gd,
                              input logic [7:0] exp_c, input logic exp_hi, input logic exp_lo,
                              input int hold);
        int lat;
        @(negedge clk);
        setpoint  = sp;
        feedback  = fb;
        kp        = gp;
        ki        = gi;
        kd        = gd;
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        check({tag, ".in_ready"}, in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 12) begin
            @(posedge clk);
            #1 lat++;
        end
        check({tag, ".latency"}, lat, 3);
        check({tag, ".control"}, control, exp_c);
        check({tag, ".sat_hi"}, sat_hi, exp_hi);
        check({tag, ".sat_lo"}, sat_lo, exp_lo);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, ".hold_ov"}, out_valid, 1);
            check({tag, ".hold_ctl"}, control, exp_c);
            check({tag, ".hold_rdy"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, ".ov_drop"}, out_valid, 0);
        check({tag, ".rdy_back"}, in_ready, 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst.out_valid", out_valid, 0);
        check("rst.control", control, 0);
        check("rst.sat_hi", sat_hi, 0);
        check("rst.sat_lo", sat_lo, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("rst.in_ready", in_ready, 1);

        // P only: 16/16 * 40
        run_sample("p_only", 8'd100, 8'd60, 8'd16, 8'd0, 8'd0, 8'd40, 1'b0, 1'b0, 0);

        // Saturation: 32*255 >> 4 = 510 -> 255; 16*(-50) >> 4 = -50 -> 0
        pulse_clear("sat");
        run_sample("sat_hi", 8'd255, 8'd0, 8'd32, 8'd0, 8'd0, 8'd255, 1'b1, 1'b0, 0);
        run_sample("sat_lo", 8'd0, 8'd50, 8'd16, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 0);

        // Integral: +80 per sample -> 5, 10, 15
        pulse_clear("int");
        run_sample("int1", 8'd20, 8'd10, 8'd0, 8'd8, 8'd0, 8'd5, 1'b0, 1'b0, 0);
        run_sample("int2", 8'd20, 8'd10, 8'd0, 8'd8, 8'd0, 8'd10, 1'b0, 1'b0, 0);
        run_sample("int3", 8'd20, 8'd10, 8'd0, 8'd8, 8'd0, 8'd15, 1'b0, 1'b0, 0);

        // Derivative: first sample forced 0, then 16*(20-10) >> 4 = 10
        pulse_clear("der");
        run_sample("der1", 8'd100, 8'd90, 8'd0, 8'd0, 8'd16, 8'd0, 1'b0, 1'b0, 0);
        run_sample("der2", 8'd100, 8'd80, 8'd0, 8'd0, 8'd16, 8'd10, 1'b0, 1'b0, 0);

        // Anti-windup: integ 1600, 3200, 4800, held at 4800; then e=-100 -> 3200 -> 200
        pulse_clear("aw");
        run_sample("aw1", 8'd100, 8'd0, 8'd0, 8'd16, 8'd0, 8'd100, 1'b0, 1'b0, 0);
        run_sample("aw2", 8'd100, 8'd0, 8'd0, 8'd16, 8'd0, 8'd200, 1'b0, 1'b0, 0);
        run_sample("aw3", 8'd100, 8'd0, 8'd0, 8'd16, 8'd0, 8'd255, 1'b1, 1'b0, 0);
        run_sample("aw4", 8'd100, 8'd0, 8'd0, 8'd16, 8'd0, 8'd255, 1'b1, 1'b0, 0);
        run_sample("aw5", 8'd0, 8'd100, 8'd0, 8'd16, 8'd0, 8'd200, 1'b0, 1'b0, 0);

        // Output stall: result held for 5 cycles with in_ready low
        pulse_clear("hs");
        run_sample("stall", 8'd100, 8'd60, 8'd16, 8'd0, 8'd0, 8'd40, 1'b0, 1'b0, 5);

        // Clear in MUL: in-flight sample dropped, integ and history reset
        pulse_clear("abort");
        run_sample("pre_abort", 8'd20, 8'd10, 8'd0, 8'd8, 8'd0, 8'd5, 1'b0, 1'b0, 0);
        @(negedge clk);
        setpoint = 8'd50;
        feedback = 8'd20;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        clear = 1'b1;
        check("abort.in_ready_clr", in_ready, 0);
        @(posedge clk);
        #1 clear = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("abort.no_ov", out_valid, 0);
            @(posedge clk);
            #1;
        end
        // integ 0 + 160 = 160 -> 10; D forced 0 (else +10)
        run_sample("post_abort", 8'd30, 8'd10, 8'd0, 8'd8, 8'd16, 8'd10, 1'b0, 1'b0, 0);

        // Clear together with in_valid in IDLE: no accept
        @(negedge clk);
        setpoint = 8'd100;
        feedback = 8'd60;
        kp       = 8'd16;
        in_valid = 1'b1;
        clear    = 1'b1;
        #1 check("clr_idle.in_ready", in_ready, 0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        clear = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("clr_idle.no_ov", out_valid, 0);
            @(posedge clk);
            #1;
        end
        check("clr_idle.in_ready_end", in_ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
